// File: rtl/tutor_ctrl_pkg.sv
// tutor_ctrl_pkg: note codes, hint LED patterns and FSM states shared by the tutor sequencer
package tutor_ctrl_pkg;
  localparam logic [3:0] N_NONE = 4'h0, N_C4 = 4'h1, N_D = 4'h2, N_E = 4'h3, N_F = 4'h4,
                         N_G = 4'h5, N_A = 4'h6, N_B = 4'h7, N_C5 = 4'h8, N_END = 4'hF;
  localparam logic [7:0] LED_C4 = 8'h01, LED_D = 8'h02, LED_E = 8'h04, LED_F = 8'h08,
                         LED_G = 8'h10, LED_A = 8'h20, LED_B = 8'h40, LED_C5 = 8'h80,
                         LED_ALL = 8'hFF;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_PRESS, S_WAIT_RELEASE, S_DONE} state_t;
  function automatic logic [7:0] onehot(input logic [3:0] n);
    case (n)
      N_C4:    return LED_C4;
      N_D:     return LED_D;
      N_E:     return LED_E;
      N_F:     return LED_F;
      N_G:     return LED_G;
      N_A:     return LED_A;
      N_B:     return LED_B;
      N_C5:    return LED_C5;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/tutor_ctrl_song_rom.sv
// song_rom: four END-terminated songs of up to 63 notes, one registered read per cycle
// Ports: CLK/RESET_N clock and async active-low reset; song_sel song index;
//   addr note position; data registered note code (END past the last note).
module song_rom
  import tutor_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] song_sel,
  input  logic [5:0] addr,
  output logic [3:0] data
);
  // note i of a song lives in the nibble at bit 4*(63-i), so the first note is the top nibble
  localparam logic [255:0] SONG0 = {N_E, N_E, N_F, N_G, N_G, N_F, N_E, N_D, N_C4, N_C4, N_D, N_E, N_E, N_D,
                                    N_E, N_E, N_F, N_G, N_G, N_F, N_E, N_D, N_C4, N_C4, N_D, N_E, N_D, N_C4,
                                    {36{N_END}}};
  localparam logic [255:0] SONG1 = {N_C4, N_D, N_E, N_F, N_G, N_A, N_B, N_C5, {56{N_END}}};
  localparam logic [255:0] SONG2 = {N_E, N_D, N_C4, N_D, N_E, N_E, N_E, N_D, N_D, N_D, N_E, N_G, N_G,
                                    N_E, N_D, N_C4, N_D, N_E, N_E, N_E, N_E, N_D, N_D, N_E, N_D, N_C4,
                                    {38{N_END}}};
  localparam logic [255:0] SONG3 = {N_C4, N_E, N_G, N_C5, N_G, N_E, N_C4, {57{N_END}}};
  logic [255:0] song;
  assign song = song_sel == 2'd0 ? SONG0 : song_sel == 2'd1 ? SONG1 : song_sel == 2'd2 ? SONG2 : SONG3;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) data <= N_END;
    else data <= song[{~addr, 2'b00} +: 4];
endmodule

// File: rtl/tutor_ctrl.sv
// tutor_ctrl: tutor-mode song sequencer driving the hint LEDs of the FPGA piano
// Ports: CLK/RESET_N clock and async active-low reset; MODE free-play override;
//   start/song_sel begin a song; note debounced key code; Led hint/flash pattern;
//   busy, song_done, err_cnt, idx status.
// TUTOR_HINT_BLINK_EN: blink the hint after HINT_TIMEOUT idle cycles in WAIT_PRESS.
module tutor_ctrl
  import tutor_ctrl_pkg::*;
#(
  parameter int unsigned HINT_TIMEOUT = 50_000_000,
  parameter int unsigned BLINK_HALF   = 12_500_000,
  parameter int unsigned DONE_CYCLES  = 100_000_000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       MODE,
  input  logic       start,
  input  logic [1:0] song_sel,
  input  logic [3:0] note,
  output logic [7:0] Led,
  output logic       busy,
  output logic       song_done,
  output logic [7:0] err_cnt,
  output logic [5:0] idx
);
  localparam logic [26:0] DONE_LAST = 27'(DONE_CYCLES - 1);
  if (DONE_CYCLES == 0 || DONE_CYCLES >= 2**27 || BLINK_HALF == 0 || BLINK_HALF >= 2**27 ||
      HINT_TIMEOUT >= 2**27) begin : g_bad_cfg
    $error("tutor_ctrl: cycle parameters must be nonzero and fit the 27-bit counters");
  end
  state_t      state_q;
  logic [1:0]  sel_q;
  logic [3:0]  exp_q, rom_q;
  logic        hit_q, load_ph_q, done_q, blink_off;
  logic [26:0] done_cnt_q;
  logic [7:0]  led_q, led_d, err_q;
  logic [5:0]  idx_q;
  song_rom u_rom (.CLK(CLK), .RESET_N(RESET_N), .song_sel(sel_q), .addr(idx_q), .data(rom_q));
`ifdef TUTOR_HINT_BLINK_EN
  localparam logic [26:0] HINT_T     = 27'(HINT_TIMEOUT);
  localparam logic [26:0] BLINK_LAST = 27'(BLINK_HALF - 1);
  logic [26:0] timer_q, blink_q;
  logic        phase_q;
  // any key or any state change restarts the idle timer; a held key always shows the hint
  assign blink_off = timer_q == HINT_T && !phase_q && note == N_NONE;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      timer_q <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
    end else if (state_q != S_WAIT_PRESS || note != N_NONE) begin
      timer_q <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
    end else if (timer_q != HINT_T) timer_q <= timer_q + 27'd1;
    else if (blink_q == BLINK_LAST) begin
      blink_q <= '0;
      phase_q <= !phase_q;
    end else blink_q <= blink_q + 27'd1;
`else
  assign blink_off = 1'b0;
`endif
  assign led_d = state_q == S_IDLE ? 8'h00 :
                 state_q == S_DONE ? LED_ALL :
                 state_q == S_WAIT_PRESS ? (blink_off ? 8'h00 : onehot(exp_q)) : led_q;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      exp_q      <= N_NONE;
      hit_q      <= 1'b0;
      load_ph_q  <= 1'b0;
      done_q     <= 1'b0;
      done_cnt_q <= '0;
      led_q      <= '0;
      err_q      <= '0;
      idx_q      <= '0;
    end else begin
      done_q <= 1'b0;
      led_q  <= led_d;
      if (MODE) begin
        state_q   <= S_IDLE;
        led_q     <= '0;
        idx_q     <= '0;
        load_ph_q <= 1'b0;
      end else case (state_q)
        S_IDLE: if (start) begin
          sel_q     <= song_sel;
          err_q     <= '0;
          idx_q     <= '0;
          load_ph_q <= 1'b0;
          state_q   <= S_LOAD;
        end
        // first LOAD cycle addresses the ROM, second one sees its registered output
        S_LOAD: begin
          load_ph_q <= !load_ph_q;
          if (load_ph_q) begin
            exp_q <= rom_q;
            if (rom_q == N_END || idx_q == 6'd63) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              done_cnt_q <= '0;
            end else state_q <= S_WAIT_PRESS;
          end
        end
        S_WAIT_PRESS: if (note != N_NONE) begin
          hit_q   <= note == exp_q;
          state_q <= S_WAIT_RELEASE;
          if (note != exp_q && err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
        S_WAIT_RELEASE: if (note == N_NONE) begin
          state_q <= hit_q ? S_LOAD : S_WAIT_PRESS;
          if (hit_q) idx_q <= idx_q + 6'd1;
        end
        S_DONE: if (done_cnt_q == DONE_LAST) begin
          state_q <= S_IDLE;
          idx_q   <= '0;
        end else done_cnt_q <= done_cnt_q + 27'd1;
        default: state_q <= S_IDLE;
      endcase
    end
  assign Led       = led_q;
  assign busy      = state_q != S_IDLE;
  assign song_done = done_q;
  assign err_cnt   = err_q;
  assign idx       = idx_q;
endmodule
